// File: rtl/tensor_core_register_file_if.sv
// ============================================================================
// Module   : tensor_core_register_file_if
// Brief    : Host byte streams and tensor-core operand/result bundle.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface tensor_core_register_file_if;
    logic                 write_valid;
    logic [7:0]           write_data;
    logic                 write_ready;
    logic [3:0][3:0][7:0] tensor_core_input1;
    logic [3:0][3:0][7:0] tensor_core_input2;
    logic                 tensor_core_register_file_write_enable;
    logic [3:0][3:0][7:0] tensor_core_output;
    logic                 is_done_with_calculation;
    logic                 result_valid;
    logic [7:0]           result_data;
    logic                 result_ready;
    logic                 busy;
    logic [7:0]           calc_cycles;

    modport slave (
        input  write_valid, write_data, tensor_core_output,
               is_done_with_calculation, result_ready,
        output write_ready, tensor_core_input1, tensor_core_input2,
               tensor_core_register_file_write_enable, result_valid,
               result_data, busy, calc_cycles
    );

    modport master (
        output write_valid, write_data, tensor_core_output,
               is_done_with_calculation, result_ready,
        input  write_ready, tensor_core_input1, tensor_core_input2,
               tensor_core_register_file_write_enable, result_valid,
               result_data, busy, calc_cycles
    );
endinterface

`default_nettype wire

// File: rtl/tensor_core_register_file.sv
// ============================================================================
// Module   : tensor_core_register_file
// Brief    : Operand/result buffer and start/done sequencer for a 4x4 MMA core.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tensor_core_register_file (
    input  wire logic                  clock_in,
    input  wire logic                  reset_in,
    tensor_core_register_file_if.slave bus
);
    typedef enum logic [1:0] {
        S_LOAD      = 2'd0,
        S_START     = 2'd1,
        S_WAIT_DONE = 2'd2,
        S_DRAIN     = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [4:0]           load_idx_q, load_idx_d;
    logic [3:0]           res_idx_q, res_idx_d;
    logic [7:0]           cyc_q, cyc_d;
    logic [7:0]           calc_q;
    logic [3:0][3:0][7:0] in1_q, in2_q, res_q;
    logic                 load_fire, done_fire, drain_fire;

    // Done is only trusted in WAIT_DONE; any earlier value is stale from a prior run.
    assign load_fire  = (state_q == S_LOAD)      && bus.write_valid;
    assign done_fire  = (state_q == S_WAIT_DONE) && bus.is_done_with_calculation;
    assign drain_fire = (state_q == S_DRAIN)     && bus.result_ready;

    always_comb begin
        state_d    = state_q;
        load_idx_d = load_idx_q;
        res_idx_d  = res_idx_q;
        cyc_d      = cyc_q;
        case (state_q)
            S_LOAD: begin
                if (load_fire) begin
                    load_idx_d = load_idx_q + 5'd1;
                    if (load_idx_q == 5'd31) state_d = S_START;
                end
            end
            S_START: begin
                cyc_d   = 8'd0;
                state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (cyc_q != 8'hFF) cyc_d = cyc_q + 8'd1;
                if (done_fire) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (drain_fire) begin
                    res_idx_d = res_idx_q + 4'd1;
                    if (res_idx_q == 4'd15) state_d = S_LOAD;
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            state_q    <= S_LOAD;
            load_idx_q <= 5'd0;
            res_idx_q  <= 4'd0;
            cyc_q      <= 8'd0;
        end else begin
            state_q    <= state_d;
            load_idx_q <= load_idx_d;
            res_idx_q  <= res_idx_d;
            cyc_q      <= cyc_d;
        end
    end

    // calc_cycles counts the detection cycle itself, hence the already-incremented cyc_d.
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            in1_q  <= '0;
            in2_q  <= '0;
            res_q  <= '0;
            calc_q <= 8'd0;
        end else begin
            if (load_fire) begin
                if (!load_idx_q[4]) in1_q[load_idx_q[3:2]][load_idx_q[1:0]] <= bus.write_data;
                else                in2_q[load_idx_q[3:2]][load_idx_q[1:0]] <= bus.write_data;
            end
            if (done_fire) begin
                res_q  <= bus.tensor_core_output;
                calc_q <= cyc_d;
            end
        end
    end

    assign bus.write_ready                            = (state_q == S_LOAD);
    assign bus.tensor_core_register_file_write_enable = (state_q == S_START);
    assign bus.result_valid                           = (state_q == S_DRAIN);
    assign bus.result_data = (state_q == S_DRAIN) ? res_q[res_idx_q[3:2]][res_idx_q[1:0]] : 8'd0;
    assign bus.busy                                   = (state_q != S_LOAD);
    assign bus.calc_cycles                            = calc_q;
    assign bus.tensor_core_input1                     = in1_q;
    assign bus.tensor_core_input2                     = in2_q;

endmodule

`default_nettype wire

// File: doc/tensor_core_register_file.md
# tensor_core_register_file

Front-end operand/result buffer for `small_tensor_core_mma`. Accepts the two 4x4 8-bit operand matrices as a byte stream and holds them stable on the core's inputs. Issues the one-cycle start pulse and waits for the core's done flag. Snapshots the 4x4 result and streams it back out byte-serially. Sits between the host byte interface and the tensor core, directly upstream (operands) and downstream (results) of the core.

## Interface
- Parameters: none; element width fixed at 8 bits, matrix dimension fixed at 4.
- clock_in  in  1  single clock; all state updates on rising edge.
- reset_in  in  1  asynchronous, active-high reset.
- write_valid  in  1  host operand byte valid.
- write_data  in  8  operand byte.
- write_ready  out  1  block accepts operand byte; a byte transfers on an edge with write_valid && write_ready.
- tensor_core_input1  out  8 x [4][4]  operand A registers, driven to the core.
- tensor_core_input2  out  8 x [4][4]  operand B registers, driven to the core.
- tensor_core_register_file_write_enable  out  1  one-cycle start pulse to the core.
- tensor_core_output  in  8 x [4][4]  core result matrix.
- is_done_with_calculation  in  1  core done flag.
- result_valid  out  1  result byte valid.
- result_data  out  8  result byte.
- result_ready  in  1  host accepts result byte.
- busy  out  1  high in any state other than LOAD.
- calc_cycles  out  8  number of WAIT_DONE cycles measured for the last calculation.

## Operation
- FSM states:
  - LOAD: write_ready=1. Accepted bytes fill a 5-bit load index 0..31. Indices 0..15 go to input1[idx/4][idx%4]; indices 16..31 go to input2[(idx-16)/4][(idx-16)%4]. Rows are filled in row-major order. Acceptance of index 31 -> START, and the index clears to 0.
  - START: write_enable=1 for exactly this cycle; write_ready=0. Clears the cycle counter. Always -> WAIT_DONE.
  - WAIT_DONE: calc_cycles counter increments every cycle and saturates at 255. When is_done_with_calculation==1 is sampled, all 16 tensor_core_output bytes are captured into result registers -> DRAIN.
    - Done is ignored in every other state. The core's done flag is stale/unknown before the enable pulse, and is only trusted from the cycle after START.
  - DRAIN: result_valid=1 and result_data=result[ridx/4][ridx%4], with ridx running 0..15. ridx advances on result_valid && result_ready. Acceptance of ridx 15 -> LOAD, and ridx clears.
- Operand registers change only in LOAD, so they are stable for the whole calculation and drain.
- write_valid is ignored outside LOAD. result_ready is ignored outside DRAIN.
- Result arithmetic is performed by the core, modulo 256: out[i][j] = sum_k A[i][k]*B[k][j] truncated to 8 bits. This block passes the result through unmodified.
- calc_cycles updates when DONE is detected and holds until the next detection.

## Timing
- Reset (asynchronous, takes effect immediately):
  - state=LOAD, load/result indices=0.
  - All operand and result registers = 0.
  - write_enable=0, result_valid=0, result_data=0, calc_cycles=0, busy=0.
  - write_ready=1 (state decode), but no byte is accepted while reset_in is high.
- Start pulse: write_enable is asserted in the cycle immediately after the edge that accepted byte 31.
- Calculation: the core needs 64 edges (16 elements x 4 MACs) after sampling the enable. Done is first seen in the 64th WAIT_DONE cycle, so calc_cycles=64 for a conforming core.
- Result output: result_valid rises the cycle after done is sampled. It holds with result_data stable while result_ready=0, and advances at most one byte per cycle. With result_ready held at 1, 16 consecutive bytes are transferred.
- End-to-end latency with no backpressure: 32 load cycles + 1 START + 64 WAIT_DONE + 16 DRAIN = 113 cycles per job.
- Back-to-back jobs: LOAD is re-entered the cycle after byte 15 is accepted, and write_ready=1 in that cycle.
- Reset mid-operation (any state): returns to LOAD with all registers cleared.
  - The core may still be running, but its done flag is ignored until the next START.
  - The next job completes correctly because the enable pulse restarts the core.
- Partial load (fewer than 32 bytes): stays in LOAD indefinitely and the index is held. No timeout.
- write_valid during START/WAIT_DONE/DRAIN: the byte is not accepted and the load index is unchanged.

## Test plan
- Identity check: A=identity, B[i][j]=4*i+j. Output is 0..15 in order; calc_cycles=64; exactly one write_enable pulse.
- Constant fill: A all 2, B all 3. All 16 result bytes = 24; busy high from START through the last DRAIN byte.
- Overflow wrap: A all 10, B all 10. Every result = 400 mod 256 = 144.
- Backpressure: toggle result_ready pseudo-randomly during DRAIN. result_data is stable while stalled; the byte sequence is unchanged; no byte is duplicated or dropped. Assert write_valid during DRAIN and check no operand register changes.
- Reset in WAIT_DONE (cycle 20): all outputs return to reset values immediately. A following full job with A=identity, B all 7 yields all-7 results and calc_cycles=64.
- Back-to-back: two jobs loaded without idle cycles. The second job's write_ready is high the cycle after the first job's 16th result byte, and both result streams are correct.
